// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath width, the canonical nop,
// the fetch FSM state encoding, the IF/ID slot layout and the major opcode
// constants that decode also relies on.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- what the IF/ID slot holds before anything is fetched
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // FAULT is only ever entered when misaligned-redirect trapping is built in
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  // Contents of the IF/ID pipeline slot as decode sees it
  typedef struct packed {
    logic            valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } if_slot_t;

  // Major opcodes (instr[6:0]) shared with the decode stage
  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

  // Extracts the major opcode field of an instruction word
  function automatic logic [6:0] opcodeOf(input logic [31:0] instr);
    return instr[6:0];
  endfunction

  // True for the control-transfer opcodes that can cause a fetch redirect
  function automatic logic isControlTransfer(input logic [31:0] instr);
    logic [6:0] opc;
    opc = opcodeOf(instr);
    return (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID slot register: holds the fetched instruction, its PC and a valid
// bit. Flush has priority over load; with neither asserted the slot holds.
// A flush only kills the valid bit, the stale data is left in place since
// nobody looks at it while valid is low.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         flush_i,
  input  logic [31:0]  instr_i,
  input  logic [W-1:0] pc_i,
  output logic         valid_o,
  output logic [31:0]  instr_o,
  output logic [W-1:0] pc_o
);

  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [W-1:0] pc_q, pc_d;

  // Next slot contents: flush beats load, otherwise hold
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end
  end

  // Slot register, reset to an empty slot holding a nop at address zero
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage. Owns the PC, presents it to a combinational
// instruction memory and registers the returned word into the IF/ID slot.
// A redirect from EX flushes the slot and reloads the PC; decode throttles
// the stage through id_ready. Sequential fetch wraps inside the memory.
//
// Build option FETCH_MISALIGN_TRAP_EN: a redirect to a non-word-aligned
// target parks the stage in FAULT with a sticky misalign_fault flag until
// reset. Without it the low two target bits are simply dropped and the
// misalign_fault port does not exist.
module fetch_stage #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              IMEM_BYTES = 64
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] PC_out,
  input  logic [31:0]     instruction,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     fetch_cnt
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            misalign_fault
`endif
);

  import riscv_pkg::*;

  localparam logic [XLEN-1:0] IMEM_SIZE  = XLEN'(IMEM_BYTES);
  localparam logic [XLEN-1:0] WORD_STEP  = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pcPlus4, pcSeq, redirectPc;
  logic [31:0]     fetchCnt_q, fetchCnt_d;
  logic            slotLoad, slotFlush, slotValid;
  logic            slotFree, redirect, handshake;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic            fault_q, fault_d;
  logic            misalignedRedirect;
`endif

  // Sequential successor wraps to zero instead of running off the last word
  assign pcPlus4 = pc_q + WORD_STEP;
  assign pcSeq   = (pcPlus4 == IMEM_SIZE) ? '0 : pcPlus4;

  // Redirect targets are folded into the memory and forced word-aligned
  assign redirectPc = (branch_target % IMEM_SIZE) & ALIGN_MASK;

  // The slot can take a new word when it is empty or being drained now
  assign slotFree  = !slotValid || id_ready;
  assign handshake = slotValid && id_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect           = branch_taken && (state_q != FAULT);
  assign misalignedRedirect = redirect && (branch_target[1:0] != 2'b00);
`else
  assign redirect = branch_taken;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a redirect overrides both stall and capture decisions
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:      state_d = RUN;
      RUN, HOLD: state_d = slotFree ? RUN : HOLD;
`ifdef FETCH_MISALIGN_TRAP_EN
      FAULT:     state_d = FAULT;
`endif
      default:   state_d = BOOT;
    endcase
    if (redirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      state_d = misalignedRedirect ? FAULT : RUN;
`else
      state_d = RUN;
`endif
    end
  end

  // FSM outputs: slot load/flush strobes and the next PC
  always_comb begin
    slotLoad  = 1'b0;
    slotFlush = 1'b0;
    pc_d      = pc_q;
    unique case (state_q)
      RUN, HOLD: begin
        if (slotFree) begin
          slotLoad = 1'b1;
          pc_d     = pcSeq;
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      FAULT: begin
        slotFlush = 1'b1;
      end
`endif
      default: begin
        slotLoad = 1'b0;
      end
    endcase
    if (redirect) begin
      slotLoad  = 1'b0;
      slotFlush = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
      pc_d      = misalignedRedirect ? pc_q : redirectPc;
`else
      pc_d      = redirectPc;
`endif
    end
  end

  // Program counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Handed-over instruction counter, wraps naturally at 32 bits
  always_comb begin
    fetchCnt_d = fetchCnt_q;
    if (handshake) begin
      fetchCnt_d = fetchCnt_q + 32'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      fetchCnt_q <= '0;
    end else begin
      fetchCnt_q <= fetchCnt_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Sticky misaligned-redirect flag, only reset clears it
  always_comb begin
    fault_d = fault_q || misalignedRedirect;
  end

  // Fault flag register
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign misalign_fault = fault_q;
`endif

  if_id_reg #(
    .W (XLEN)
  ) u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (slotLoad),
    .flush_i (slotFlush),
    .instr_i (instruction),
    .pc_i    (pc_q),
    .valid_o (slotValid),
    .instr_o (if_instr),
    .pc_o    (if_pc)
  );

  assign PC_out    = pc_q;
  assign if_valid  = slotValid;
  assign fetch_cnt = fetchCnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: a small instruction memory model answers
// PC_out combinationally, per-cycle vectors give the expected registered
// outputs, and a scoreboard checks every instruction handed to decode.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        branchTaken = 1'b0;
  logic [31:0] branchTarget = '0;
  logic        idReady = 1'b0;
  logic [31:0] pcOut;
  logic [31:0] instruction;
  logic        ifValid;
  logic [31:0] ifInstr;
  logic [31:0] ifPc;
  logic [31:0] fetchCnt;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalignFault;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        rst;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic        chkSlot;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eins;
    logic [31:0] epcout;
    logic [31:0] ecnt;
    logic        efault;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];

  logic        prevValid = 1'b0;
  logic [31:0] prevPc = '0;
  logic [31:0] prevIns = '0;

  // 16-word instruction memory contents
  function automatic logic [31:0] memWord(input logic [3:0] idx);
    case (idx)
      4'd0:    return 32'h0000_0033;
      4'd1:    return 32'h4000_0033;
      4'd9:    return 32'h0000_0063;
      default: return 32'h0000_0013 | ({28'h0, idx} << 7);
    endcase
  endfunction

  function automatic logic [31:0] wAt(input logic [31:0] addr);
    return memWord(addr[5:2]);
  endfunction

  function automatic vec_t mkVec(input logic rst, input logic br, input logic [31:0] tgt,
                                 input logic rdy, input logic chkSlot, input logic ev,
                                 input logic [31:0] epc, input logic [31:0] eins,
                                 input logic [31:0] epcout, input logic [31:0] ecnt,
                                 input logic efault);
    vec_t v;
    v.rst = rst; v.br = br; v.tgt = tgt; v.rdy = rdy; v.chkSlot = chkSlot;
    v.ev = ev; v.epc = epc; v.eins = eins; v.epcout = epcout; v.ecnt = ecnt;
    v.efault = efault;
    return v;
  endfunction

  assign instruction = wAt(pcOut);

  always #5 clk = ~clk;

  fetch_stage #(
    .XLEN       (32),
    .RESET_PC   (32'h0),
    .IMEM_BYTES (64)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .PC_out         (pcOut),
    .instruction    (instruction),
    .branch_taken   (branchTaken),
    .branch_target  (branchTarget),
    .id_ready       (idReady),
    .if_valid       (ifValid),
    .if_instr       (ifInstr),
    .if_pc          (ifPc),
    .fetch_cnt      (fetchCnt)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_fault (misalignFault)
`endif
  );

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one vector, queue the handshake it implies, advance one edge
  task automatic applyStimulus(input vec_t v);
    sb_t e;
    reset        = v.rst;
    branchTaken  = v.br;
    branchTarget = v.tgt;
    idReady      = v.rdy;
    if (!v.rst && v.rdy && prevValid) begin
      e.pc    = prevPc;
      e.instr = prevIns;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    prevValid = v.ev;
    prevPc    = v.epc;
    prevIns   = v.eins;
  endtask

  task automatic checkOutput(input vec_t v, input string tag, input int idx);
    checkVal($sformatf("%s[%0d].valid", tag, idx), {31'h0, ifValid}, {31'h0, v.ev});
    checkVal($sformatf("%s[%0d].PC_out", tag, idx), pcOut, v.epcout);
    checkVal($sformatf("%s[%0d].cnt", tag, idx), fetchCnt, v.ecnt);
    if (v.chkSlot) begin
      checkVal($sformatf("%s[%0d].if_pc", tag, idx), ifPc, v.epc);
      checkVal($sformatf("%s[%0d].if_instr", tag, idx), ifInstr, v.eins);
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    checkVal($sformatf("%s[%0d].fault", tag, idx), {31'h0, misalignFault}, {31'h0, v.efault});
`endif
  endtask

  task automatic runVecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], tag, i);
    end
    vecs.delete();
  endtask

  // Scoreboard: a handshake happens on the coming edge, compare the slot
  always @(negedge clk) begin
    sb_t e;
    if (!reset && idReady && ifValid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb.unexpected: got pc %h with no expected entry", ifPc);
      end else begin
        e = sbq.pop_front();
        checkVal("sb.pc", ifPc, e.pc);
        checkVal("sb.instr", ifInstr, e.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // rst br tgt rdy chkSlot | ev if_pc if_instr PC_out cnt fault
    vecs.push_back(mkVec(1, 0, 0,  1, 1, 0, 0,  NOP,      0,  0, 0)); // reset state
    vecs.push_back(mkVec(0, 0, 0,  1, 1, 0, 0,  NOP,      0,  0, 0)); // boot bubble
    vecs.push_back(mkVec(0, 0, 0,  1, 1, 1, 0,  wAt(0),   4,  0, 0));
    vecs.push_back(mkVec(0, 0, 0,  1, 1, 1, 4,  wAt(4),   8,  1, 0));
    vecs.push_back(mkVec(0, 0, 0,  1, 1, 1, 8,  wAt(8),   12, 2, 0));
    vecs.push_back(mkVec(0, 0, 0,  0, 1, 1, 8,  wAt(8),   12, 2, 0)); // stall x3
    vecs.push_back(mkVec(0, 0, 0,  0, 1, 1, 8,  wAt(8),   12, 2, 0));
    vecs.push_back(mkVec(0, 0, 0,  0, 1, 1, 8,  wAt(8),   12, 2, 0));
    vecs.push_back(mkVec(0, 0, 0,  1, 1, 1, 12, wAt(12),  16, 3, 0));
    vecs.push_back(mkVec(0, 1, 36, 0, 0, 0, 0,  0,        36, 3, 0)); // redirect while stalled
    vecs.push_back(mkVec(0, 0, 0,  0, 1, 1, 36, 32'h63,   40, 3, 0));
    vecs.push_back(mkVec(0, 0, 0,  1, 1, 1, 40, wAt(40),  44, 4, 0));
    vecs.push_back(mkVec(0, 1, 56, 1, 0, 0, 0,  0,        56, 5, 0)); // redirect with handshake
    vecs.push_back(mkVec(0, 0, 0,  1, 1, 1, 56, wAt(56),  60, 5, 0));
    vecs.push_back(mkVec(0, 0, 0,  1, 1, 1, 60, wAt(60),  0,  6, 0)); // wrap
    vecs.push_back(mkVec(0, 0, 0,  1, 1, 1, 0,  wAt(0),   4,  7, 0));
    vecs.push_back(mkVec(0, 0, 0,  1, 1, 1, 4,  wAt(4),   8,  8, 0));
    vecs.push_back(mkVec(0, 1, 72, 0, 0, 0, 0,  0,        8,  8, 0)); // target folded mod 64
    vecs.push_back(mkVec(0, 0, 0,  1, 1, 1, 8,  wAt(8),   12, 8, 0));
    vecs.push_back(mkVec(0, 0, 0,  0, 1, 1, 8,  wAt(8),   12, 8, 0)); // into HOLD
    vecs.push_back(mkVec(1, 1, 36, 0, 1, 0, 0,  NOP,      0,  0, 0)); // reset beats redirect
    vecs.push_back(mkVec(0, 0, 0,  0, 1, 0, 0,  NOP,      0,  0, 0));
    vecs.push_back(mkVec(0, 0, 0,  0, 1, 1, 0,  wAt(0),   4,  0, 0));
    vecs.push_back(mkVec(1, 0, 0,  0, 1, 0, 0,  NOP,      0,  0, 0));
    vecs.push_back(mkVec(0, 1, 16, 1, 0, 0, 0,  0,        16, 0, 0)); // redirect during boot
    vecs.push_back(mkVec(0, 0, 0,  1, 1, 1, 16, wAt(16),  20, 0, 0));
    vecs.push_back(mkVec(0, 0, 0,  1, 1, 1, 20, wAt(20),  24, 1, 0));
    runVecs("tbl");

    // Misaligned redirect target
    vecs.push_back(mkVec(1, 0, 0,  0, 1, 0, 0,  NOP,      0,  0, 0));
    vecs.push_back(mkVec(0, 0, 0,  0, 1, 0, 0,  NOP,      0,  0, 0));
    vecs.push_back(mkVec(0, 0, 0,  0, 1, 1, 0,  wAt(0),   4,  0, 0));
`ifdef FETCH_MISALIGN_TRAP_EN
    vecs.push_back(mkVec(0, 1, 32'h22, 0, 0, 0, 0, 0,     4,  0, 1));
    for (int i = 0; i < 5; i++) begin
      vecs.push_back(mkVec(0, 0, 0, 1, 0, 0, 0, 0,        4,  0, 1));
    end
    vecs.push_back(mkVec(1, 0, 0,  0, 1, 0, 0,  NOP,      0,  0, 0));
`else
    vecs.push_back(mkVec(0, 1, 32'h22, 0, 0, 0, 0, 0,     32'h20, 0, 0));
    vecs.push_back(mkVec(0, 0, 0,  0, 1, 1, 32'h20, wAt(32'h20), 32'h24, 0, 0));
    vecs.push_back(mkVec(0, 0, 0,  1, 1, 1, 32'h24, wAt(32'h24), 32'h28, 1, 0));
`endif
    runVecs("mis");

    idReady     = 1'b0;
    branchTaken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("sb.drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
